// File: rtl/mem_io_responder.sv
// Responder for the byte-serial memory bus: byte RAM with one-cycle read
// latency plus a UART window at 0x30000 (TX/RX FIFOs) and a sim-halt flag.
module mem_io_responder #(
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned FIFO_WIDTH     = 3,
   parameter int unsigned FULL_MARGIN    = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        uart_tx_valid,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_ready,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   output logic        uart_rx_ready,
   output logic        sim_halt
);

   localparam int unsigned DEPTH    = 1 << FIFO_WIDTH;
   localparam int unsigned CW       = FIFO_WIDTH + 1;
   localparam int unsigned RAM_SIZE = 1 << RAM_ADDR_WIDTH;

   logic [7:0] ram    [RAM_SIZE];
   logic [7:0] tx_buf [DEPTH];
   logic [7:0] rx_buf [DEPTH];

   logic [FIFO_WIDTH-1:0] tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
   logic [CW-1:0]         tx_count, rx_count;
   logic [31:0]           last_a;
   logic                  last_wr;
   logic                  last_vld;

   logic [RAM_ADDR_WIDTH-1:0] ram_idx_c;
   logic                      is_io_c, sel_data_c, sel_stat_c, first_c;
   logic                      ram_we_c, tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;
   logic                      halt_set_c, rx_nonempty_c;
   logic [CW-1:0]             tx_count_nxt_c, rx_count_nxt_c;
   logic [7:0]                io_rdata_c;
   logic                      unused_a_hi;

   assign unused_a_hi  = ^mem_a[31:18];
   assign uart_tx_data = tx_buf[tx_rd_ptr];

   // Address decode, first-cycle detection, FIFO handshakes and next counts
   always_comb begin
      ram_idx_c     = mem_a[RAM_ADDR_WIDTH-1:0];
      is_io_c       = (mem_a[17:16] == 2'b11);
      sel_data_c    = is_io_c && (mem_a[15:0] == 16'h0000);
      sel_stat_c    = is_io_c && (mem_a[15:0] == 16'h0004);
      first_c       = !(last_vld && (last_a == mem_a) && (last_wr == mem_wr));
      rx_nonempty_c = (rx_count != CW'(0));

      ram_we_c   = rdy_in && !is_io_c && mem_wr;
      halt_set_c = rdy_in && sel_stat_c && mem_wr;
      tx_pop_c   = rdy_in && uart_tx_valid && uart_tx_ready;
      tx_push_c  = rdy_in && sel_data_c && mem_wr && first_c &&
                   ((tx_count != CW'(DEPTH)) || tx_pop_c);
      rx_pop_c   = rdy_in && sel_data_c && !mem_wr && first_c && rx_nonempty_c;
      rx_push_c  = rdy_in && uart_rx_valid && uart_rx_ready &&
                   ((rx_count != CW'(DEPTH)) || rx_pop_c);

      tx_count_nxt_c = tx_count + CW'(tx_push_c) - CW'(tx_pop_c);
      rx_count_nxt_c = rx_count + CW'(rx_push_c) - CW'(rx_pop_c);

      io_rdata_c = 8'h00;
      if (sel_data_c && rx_nonempty_c) io_rdata_c = rx_buf[rx_rd_ptr];
      else if (sel_stat_c)             io_rdata_c = {7'b0, rx_nonempty_c};
   end

   // Storage arrays; contents survive reset, nothing lands while in reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         if (ram_we_c)  ram[ram_idx_c]    <= mem_dout;
         if (tx_push_c) tx_buf[tx_wr_ptr] <= mem_dout;
         if (rx_push_c) rx_buf[rx_wr_ptr] <= uart_rx_data;
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         mem_din        <= 8'h00;
         io_buffer_full <= 1'b0;
         uart_tx_valid  <= 1'b0;
         uart_rx_ready  <= 1'b1;
         sim_halt       <= 1'b0;
         tx_rd_ptr      <= '0;
         tx_wr_ptr      <= '0;
         rx_rd_ptr      <= '0;
         rx_wr_ptr      <= '0;
         tx_count       <= '0;
         rx_count       <= '0;
         last_a         <= 32'h0;
         last_wr        <= 1'b0;
         last_vld       <= 1'b0;
      end else if (rdy_in) begin
         last_a   <= mem_a;
         last_wr  <= mem_wr;
         last_vld <= 1'b1;
         if (!mem_wr) mem_din <= is_io_c ? io_rdata_c : ram[ram_idx_c];
         if (halt_set_c) sim_halt <= 1'b1;
         if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + FIFO_WIDTH'(1);
         if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + FIFO_WIDTH'(1);
         if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + FIFO_WIDTH'(1);
         if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + FIFO_WIDTH'(1);
         tx_count       <= tx_count_nxt_c;
         rx_count       <= rx_count_nxt_c;
         uart_tx_valid  <= (tx_count_nxt_c != CW'(0));
         uart_rx_ready  <= (rx_count_nxt_c != CW'(DEPTH));
         io_buffer_full <= ((CW'(DEPTH) - tx_count_nxt_c) <= CW'(FULL_MARGIN));
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: expected read bytes and TX bytes are
// queued at stimulus time and retired by a negedge monitor.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout, mem_din;
   logic        io_buffer_full, uart_tx_valid, uart_tx_ready;
   logic [7:0]  uart_tx_data, uart_rx_data;
   logic        uart_rx_valid, uart_rx_ready, sim_halt;

   int          vecs = 0;
   int          errs = 0;
   logic [7:0]  rd_q[$];
   logic [7:0]  tx_q[$];
   bit          rd_chk = 1'b0;
   bit          chk_d  = 1'b0;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full),
      .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
      .uart_tx_ready(uart_tx_ready),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
      .uart_rx_ready(uart_rx_ready), .sim_halt(sim_halt)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // one bus cycle; a checked read queues its expected byte for the monitor
   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input bit chk, input logic [7:0] exp);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      rd_chk   = chk;
      if (chk) rd_q.push_back(exp);
      @(posedge clk_in);
      #1;
      rd_chk = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   always @(posedge clk_in) chk_d <= rd_chk;

   // monitor: read data the cycle after a checked read, TX bytes on handshake
   always @(negedge clk_in) begin
      if (chk_d) begin
         if (rd_q.size() == 0) check("rd_q_underflow", 8'h01, 8'h00);
         else check("mem_din", mem_din, rd_q.pop_front());
      end
      if (rst_in && rdy_in && uart_tx_valid && uart_tx_ready) begin
         if (tx_q.size() == 0) check("tx_unexpected", uart_tx_data, 8'hxx);
         else check("uart_tx_data", uart_tx_data, tx_q.pop_front());
      end
   end

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1;
      mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h0;
      uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
      @(posedge clk_in); #1;
      idle(2);
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_full", 8'(io_buffer_full), 8'h00);
      check("rst_tx_valid", 8'(uart_tx_valid), 8'h00);
      check("rst_rx_ready", 8'(uart_rx_ready), 8'h01);
      check("rst_halt", 8'(sim_halt), 8'h00);
      rst_in = 1'b1;
      idle(1);

      // RAM write then read, one-cycle latency
      bus(32'h10, 1'b1, 8'hA5, 1'b0, 8'h00);
      bus(32'h10, 1'b0, 8'h00, 1'b1, 8'hA5);
      // 4-byte store then byte reads
      bus(32'h20, 1'b1, 8'h44, 1'b0, 8'h00);
      bus(32'h21, 1'b1, 8'h33, 1'b0, 8'h00);
      bus(32'h22, 1'b1, 8'h22, 1'b0, 8'h00);
      bus(32'h23, 1'b1, 8'h11, 1'b0, 8'h00);
      bus(32'h20, 1'b0, 8'h00, 1'b1, 8'h44);
      bus(32'h21, 1'b0, 8'h00, 1'b1, 8'h33);
      bus(32'h22, 1'b0, 8'h00, 1'b1, 8'h22);
      bus(32'h23, 1'b0, 8'h00, 1'b1, 8'h11);

      // RX path: two bytes, status, pops, empty reads
      uart_rx_valid = 1'b1; uart_rx_data = 8'h31; idle(1);
      uart_rx_data = 8'h32; idle(1);
      uart_rx_valid = 1'b0;
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h01);
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h31);
      idle(1);
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h32);
      idle(1);
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h00);
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00);
      bus(32'h30008, 1'b0, 8'h00, 1'b1, 8'h00);
      // RX fills to depth, ready drops, one pop reopens it
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uart_rx_data = 8'h80 + 8'(i);
         idle(1);
      end
      uart_rx_valid = 1'b0;
      check("rx_ready_full", 8'(uart_rx_ready), 8'h00);
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h80);
      check("rx_ready_reopen", 8'(uart_rx_ready), 8'h01);
      idle(1);

      // TX back-pressure: full flag at 6, drop at 9, drain in order
      for (int i = 0; i < 9; i++) begin
         if (i < 8) tx_q.push_back(8'h50 + 8'(i));
         bus(32'h30000, 1'b1, 8'h50 + 8'(i), 1'b0, 8'h00);
         idle(1);
         if (i == 4) check("full_after5", 8'(io_buffer_full), 8'h00);
         if (i == 5) check("full_after6", 8'(io_buffer_full), 8'h01);
      end
      uart_tx_ready = 1'b1;
      idle(12);
      check("tx_drained", 8'(tx_q.size()), 8'h00);
      check("tx_valid_empty", 8'(uart_tx_valid), 8'h00);
      check("full_clear", 8'(io_buffer_full), 8'h00);

      // simultaneous push and pop at full keeps all eight bytes
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tx_q.push_back(8'h60 + 8'(i));
         bus(32'h30000, 1'b1, 8'h60 + 8'(i), 1'b0, 8'h00);
         idle(1);
      end
      tx_q.push_back(8'h68);
      uart_tx_ready = 1'b1;
      bus(32'h30000, 1'b1, 8'h68, 1'b0, 8'h00);
      uart_tx_ready = 1'b0;
      check("full_after_swap", 8'(io_buffer_full), 8'h01);
      uart_tx_ready = 1'b1;
      idle(12);
      check("swap_drained", 8'(tx_q.size()), 8'h00);

      // rdy_in low holds outputs and suppresses the push
      bus(32'h10, 1'b0, 8'h00, 1'b1, 8'hA5);
      rdy_in = 1'b0;
      bus(32'h20, 1'b0, 8'h00, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h70, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h70, 1'b0, 8'h00);
      check("hold_mem_din", mem_din, 8'hA5);
      check("hold_tx_valid", 8'(uart_tx_valid), 8'h00);
      rdy_in = 1'b1;
      tx_q.push_back(8'h70);
      bus(32'h30000, 1'b1, 8'h70, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h70, 1'b0, 8'h00);
      idle(5);
      check("one_push", 8'(tx_q.size()), 8'h00);

      // sim_halt sticky, reset clears it and blocks the in-flight write
      uart_tx_ready = 1'b0;
      bus(32'h40, 1'b1, 8'h12, 1'b0, 8'h00);
      bus(32'h30000, 1'b1, 8'h99, 1'b0, 8'h00);
      bus(32'h30004, 1'b1, 8'h00, 1'b0, 8'h00);
      idle(3);
      check("halt_set", 8'(sim_halt), 8'h01);
      check("tx_valid_pre", 8'(uart_tx_valid), 8'h01);
      bus(32'h10, 1'b0, 8'h00, 1'b1, 8'hA5);
      rst_in = 1'b0;
      bus(32'h40, 1'b1, 8'hEE, 1'b0, 8'h00);
      bus(32'h40, 1'b1, 8'hEE, 1'b0, 8'h00);
      rst_in = 1'b1;
      check("rst2_halt", 8'(sim_halt), 8'h00);
      check("rst2_tx_valid", 8'(uart_tx_valid), 8'h00);
      check("rst2_mem_din", mem_din, 8'h00);
      check("rst2_full", 8'(io_buffer_full), 8'h00);
      check("rst2_rx_ready", 8'(uart_rx_ready), 8'h01);
      bus(32'h40, 1'b0, 8'h00, 1'b1, 8'h12);
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h00);
      idle(2);
      check("rd_q_empty", 8'(rd_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
